// File: rtl/subsystem_pkg.sv
// Constants and state encoding shared by the AS5600 target emulator and the I2C master.
package subsystem_pkg;

   localparam logic [6:0] AS5600_ADDR = 7'h36;

   localparam logic [7:0] REG_STATUS = 8'h0B;
   localparam logic [7:0] REG_RAW_HI = 8'h0C;
   localparam logic [7:0] REG_RAW_LO = 8'h0D;
   localparam logic [7:0] REG_ANG_HI = 8'h0E;
   localparam logic [7:0] REG_ANG_LO = 8'h0F;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_WR_PTR,
      ST_PTR_ACK,
      ST_WR_DATA,
      ST_RD_DATA,
      ST_RD_ACK,
      ST_WAIT_STOP
   } i2c_tgt_state_e;

   // snap = {magnet_ok, angle[11:0]}
   function automatic logic [7:0] as5600_reg_map(input logic [7:0] ptr, input logic [12:0] snap);
      logic [7:0] b;
      b = '0;
      case (ptr)
         REG_STATUS:             b = {2'b00, snap[12], ~snap[12], 1'b0, 3'b000};
         REG_RAW_HI, REG_ANG_HI: b = {4'h0, snap[11:8]};
         REG_RAW_LO, REG_ANG_LO: b = snap[7:0];
         default:                b = '0;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA and produces registered SCL edge and START/STOP pulses.
module i2c_bus_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic scl,
   input  logic sda_in,
   output logic sda_s,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
   logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
   logic scl_prev_q, sda_prev_q;
   logic scl_rise_q, scl_rise_d, scl_fall_q, scl_fall_d;
   logic start_q, start_d, stop_q, stop_d;
   logic scl_cur, sda_cur;

   always_comb begin
      scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_cur    = scl_sync_q[SYNC_STAGES-1];
      sda_cur    = sda_sync_q[SYNC_STAGES-1];
      scl_rise_d = scl_cur & ~scl_prev_q;
      scl_fall_d = ~scl_cur & scl_prev_q;
      // SCL must be high on both samples, so an SDA change alongside an SCL edge is never START/STOP
      start_d    = scl_cur & scl_prev_q & sda_prev_q & ~sda_cur;
      stop_d     = scl_cur & scl_prev_q & ~sda_prev_q & sda_cur;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
         scl_rise_q <= 1'b0;
         scl_fall_q <= 1'b0;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_prev_q <= scl_cur;
         sda_prev_q <= sda_cur;
         scl_rise_q <= scl_rise_d;
         scl_fall_q <= scl_fall_d;
         start_q    <= start_d;
         stop_q     <= stop_d;
      end
   end

   assign sda_s     = sda_prev_q;
   assign scl_rise  = scl_rise_q;
   assign scl_fall  = scl_fall_q;
   assign start_det = start_q;
   assign stop_det  = stop_q;

endmodule

// File: rtl/as5600_i2c_target.sv
// I2C target emulating the AS5600 register map, serving a supplied angle and magnet status.
module as5600_i2c_target
   import subsystem_pkg::*;
#(
   parameter logic [6:0]  DEV_ADDR    = AS5600_ADDR,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        scl,
   input  logic        sda_in,
   output logic        sda_oe,
   input  logic [11:0] angle_value,
   input  logic        magnet_ok,
   output logic        busy,
   output logic        rd_done
);

   logic sda_s, scl_rise, scl_fall, start_det, stop_det;

   i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clock     (clock),
      .reset     (reset),
      .scl       (scl),
      .sda_in    (sda_in),
      .sda_s     (sda_s),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   i2c_tgt_state_e state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [6:0]  shift_q, shift_d;
   logic [6:0]  tx_q, tx_d;
   logic [7:0]  reg_ptr_q, reg_ptr_d;
   logic [12:0] snapshot_q, snapshot_d;
   logic [7:0]  rd_byte;
   logic        rw_q, rw_d;
   logic        sda_oe_q, sda_oe_d;
   logic        busy_q, busy_d;
   logic        rd_done_q, rd_done_d;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      reg_ptr_d  = reg_ptr_q;
      snapshot_d = snapshot_q;
      rw_d       = rw_q;
      sda_oe_d   = sda_oe_q;
      busy_d     = busy_q;
      rd_done_d  = 1'b0;
      rd_byte    = as5600_reg_map(reg_ptr_q, snapshot_q);

      if (start_det) begin
         state_d   = ST_ADDR;
         bit_cnt_d = '0;
         busy_d    = 1'b1;
         sda_oe_d  = 1'b0;
      end else if (stop_det) begin
         state_d  = ST_IDLE;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else begin
         case (state_q)
            ST_ADDR, ST_WR_PTR, ST_WR_DATA: begin
               if (scl_rise) begin
                  shift_d   = {shift_q[5:0], sda_s};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     if (state_q == ST_ADDR) begin
                        rw_d    = sda_s;
                        state_d = (shift_q == DEV_ADDR) ? ST_ADDR_ACK : ST_IDLE;
                     end else begin
                        reg_ptr_d = (state_q == ST_WR_PTR) ? {shift_q, sda_s} : reg_ptr_q + 8'd1;
                        state_d   = ST_PTR_ACK;
                     end
                  end
               end
            end
            // sda_oe_q doubles as the ACK phase: first fall pulls low, second fall releases
            ST_ADDR_ACK, ST_PTR_ACK: begin
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else if (state_q == ST_ADDR_ACK && rw_q) begin
                     snapshot_d = {magnet_ok, angle_value};
                     rd_byte    = as5600_reg_map(reg_ptr_q, {magnet_ok, angle_value});
                     tx_d       = rd_byte[6:0];
                     sda_oe_d   = ~rd_byte[7];
                     state_d    = ST_RD_DATA;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = (state_q == ST_ADDR_ACK) ? ST_WR_PTR : ST_WR_DATA;
                  end
               end
            end
            ST_RD_DATA: begin
               if (scl_fall) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  tx_d      = {tx_q[5:0], 1'b0};
                  if (bit_cnt_q == 3'd7) begin
                     sda_oe_d = 1'b0;
                     state_d  = ST_RD_ACK;
                  end else begin
                     sda_oe_d = ~tx_q[6];
                  end
               end
            end
            // a fall seen here always follows an ACKed rise, so it starts the next byte
            ST_RD_ACK: begin
               if (scl_rise) begin
                  rd_done_d = 1'b1;
                  reg_ptr_d = reg_ptr_q + 8'd1;
                  if (sda_s) state_d = ST_WAIT_STOP;
               end else if (scl_fall) begin
                  tx_d     = rd_byte[6:0];
                  sda_oe_d = ~rd_byte[7];
                  state_d  = ST_RD_DATA;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         tx_q       <= '0;
         reg_ptr_q  <= 8'h00;
         snapshot_q <= '0;
         rw_q       <= 1'b0;
         sda_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         rd_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         reg_ptr_q  <= reg_ptr_d;
         snapshot_q <= snapshot_d;
         rw_q       <= rw_d;
         sda_oe_q   <= sda_oe_d;
         busy_q     <= busy_d;
         rd_done_q  <= rd_done_d;
      end
   end

   assign sda_oe  = sda_oe_q;
   assign busy    = busy_q;
   assign rd_done = rd_done_q;

endmodule

// File: tb/tb_as5600_i2c_target.sv
// Bench for the AS5600 target: bit-banged I2C master plus a register-map reference model.
module tb_as5600_i2c_target;

   localparam int Q = 100;
   localparam logic [6:0] DEV = 7'h36;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        scl   = 1'b1;
   logic        sda_m = 1'b1;
   logic        sda_in;
   logic        sda_oe, busy, rd_done;
   logic [11:0] angle_value = 12'h000;
   logic        magnet_ok = 1'b1;

   int tests = 0;
   int fails = 0;
   int rd_done_cnt = 0;
   int oe_cycles = 0;

   int model_ptr = 0;
   int snap_ang  = 0;
   int snap_mag  = 0;

   assign sda_in = sda_m & ~sda_oe;

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (rd_done === 1'b1) rd_done_cnt++;
      if (sda_oe === 1'b1) oe_cycles++;
   end

   as5600_i2c_target #(.DEV_ADDR(DEV), .SYNC_STAGES(2)) dut (
      .clock       (clock),
      .reset       (reset),
      .scl         (scl),
      .sda_in      (sda_in),
      .sda_oe      (sda_oe),
      .angle_value (angle_value),
      .magnet_ok   (magnet_ok),
      .busy        (busy),
      .rd_done     (rd_done)
   );

   function automatic int ref_byte(input int p, input int ang, input int mag);
      if (p == 11) return (mag != 0) ? 32 : 16;
      if (p == 12 || p == 14) return ang / 256;
      if (p == 13 || p == 15) return ang % 256;
      return 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; #Q; scl = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0; #Q;
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #Q;
   endtask

   task automatic wbyte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) begin
         sda_m = b[i]; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
      end
      sda_m = 1'b1; #Q; scl = 1'b1; #Q; ack = sda_in; #Q; scl = 1'b0; #Q;
   endtask

   task automatic rbyte(input logic nack, output logic [7:0] b);
      sda_m = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         #Q; scl = 1'b1; #Q; b[i] = sda_in; #Q; scl = 1'b0; #Q;
      end
      sda_m = nack; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
      sda_m = 1'b1;
   endtask

   task automatic set_ptr(input logic [7:0] p);
      logic ack;
      i2c_start();
      wbyte({DEV, 1'b0}, ack);
      chk("wr_addr_ack", ack, 0);
      wbyte(p, ack);
      chk("ptr_ack", ack, 0);
      model_ptr = p;
   endtask

   task automatic rd_start();
      logic ack;
      snap_ang = angle_value;
      snap_mag = magnet_ok;
      i2c_start();
      wbyte({DEV, 1'b1}, ack);
      chk("rd_addr_ack", ack, 0);
   endtask

   task automatic rd_chk(input string tag, input logic nack);
      logic [7:0] b;
      rbyte(nack, b);
      chk(tag, b, ref_byte(model_ptr, snap_ang, snap_mag));
      model_ptr = (model_ptr + 1) % 256;
   endtask

   initial begin
      int r0, oe0, n;
      logic ack;

      #50;
      reset = 1'b0;
      #20;
      chk("rst_sda_oe", sda_oe, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rd_done", rd_done, 0);

      // 1: pointer write, repeated START, two-byte read
      angle_value = 12'hABC; magnet_ok = 1'b1;
      r0 = rd_done_cnt;
      set_ptr(8'h0C);
      chk("t1_busy", busy, 1);
      rd_start();
      rd_chk("t1_byte0", 1'b0);
      rd_chk("t1_byte1", 1'b1);
      i2c_stop();
      chk("t1_rd_done", rd_done_cnt - r0, 2);
      chk("t1_sda_oe", sda_oe, 0);
      chk("t1_busy_end", busy, 0);

      // 2: foreign address
      oe0 = oe_cycles;
      i2c_start();
      wbyte({7'h37, 1'b0}, ack);
      chk("t2_nack", ack, 1);
      chk("t2_busy", busy, 1);
      i2c_stop();
      chk("t2_busy_end", busy, 0);
      chk("t2_no_oe", oe_cycles - oe0, 0);

      // 3: angle changes between bytes; snapshot must hold
      angle_value = 12'h123;
      set_ptr(8'h0C);
      rd_start();
      rd_chk("t3_byte0", 1'b0);
      angle_value = 12'hFFF;
      rd_chk("t3_byte1", 1'b1);
      i2c_stop();

      // 4: STATUS with both magnet states
      magnet_ok = 1'b1;
      set_ptr(8'h0B);
      rd_start();
      rd_chk("t4_status_md", 1'b1);
      i2c_stop();
      magnet_ok = 1'b0;
      set_ptr(8'h0B);
      rd_start();
      rd_chk("t4_status_ml", 1'b1);
      i2c_stop();

      // 5: pointer wrap, then read 0x01..0x0C without rewriting the pointer
      magnet_ok = 1'b1; angle_value = 12'h5A7;
      set_ptr(8'hFF);
      rd_start();
      rd_chk("t5_ff", 1'b0);
      rd_chk("t5_00", 1'b1);
      i2c_stop();
      chk("t5_model_ptr", model_ptr, 1);
      rd_start();
      for (int i = 0; i < 12; i++) rd_chk($sformatf("t5_walk_%0h", model_ptr), (i == 11));
      i2c_stop();

      // data write advances the pointer
      set_ptr(8'h0A);
      wbyte(8'h55, ack);
      chk("wd_ack", ack, 0);
      model_ptr++;
      rd_start();
      rd_chk("wd_status", 1'b1);
      i2c_stop();

      // 6: reset while target drives a 0 bit
      angle_value = 12'hABC;
      set_ptr(8'h0C);
      rd_start();
      #Q;
      chk("t6_driving", sda_oe, 1);
      reset = 1'b1;
      #10;
      chk("t6_rst_sda_oe", sda_oe, 0);
      chk("t6_rst_busy", busy, 0);
      reset = 1'b0;
      #10;
      i2c_stop();
      set_ptr(8'h0C);
      rd_start();
      rd_chk("t6_byte0", 1'b0);
      rd_chk("t6_byte1", 1'b1);
      i2c_stop();

      // randomized reads against the model
      for (int it = 0; it < 6; it++) begin
         angle_value = 12'($urandom_range(0, 4095));
         magnet_ok   = 1'($urandom_range(0, 1));
         n  = $urandom_range(1, 3);
         r0 = rd_done_cnt;
         set_ptr(8'($urandom_range(10, 16)));
         rd_start();
         for (int k = 0; k < n; k++) rd_chk($sformatf("rnd%0d_b%0d", it, k), (k == n - 1));
         i2c_stop();
         chk($sformatf("rnd%0d_rd_done", it), rd_done_cnt - r0, n);
         chk($sformatf("rnd%0d_busy", it), busy, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
